// File: rtl/keycode_event_gen_pkg.sv
// keycode_evt_pkg: shared event, FIFO entry and FSM state types for keycode_event_gen
package keycode_evt_pkg;
  typedef enum logic [1:0] {
    EVT_NONE    = 2'b00,
    EVT_PRESS   = 2'b01,
    EVT_RELEASE = 2'b10,
    EVT_REPEAT  = 2'b11
  } evt_type_t;
  typedef struct packed {
    evt_type_t  etype;
    logic [7:0] code;
  } key_evt_t;
  typedef enum logic [1:0] {
    IDLE,
    EMIT_REL,
    EMIT_PRESS,
    HELD
  } state_t;
endpackage

// File: rtl/keycode_event_gen_if.sv
// keycode_event_gen_if: valid/ready key event stream from generator (master) to consumer (slave)
interface keycode_event_gen_if;
  import keycode_evt_pkg::*;
  logic       evt_valid;
  logic       evt_ready;
  evt_type_t  evt_type;
  logic [7:0] evt_code;
  modport master(output evt_valid, evt_type, evt_code, input evt_ready);
  modport slave(input evt_valid, evt_type, evt_code, output evt_ready);
endinterface

// File: rtl/keycode_event_gen_fifo.sv
// evt_fifo: show-ahead synchronous FIFO of key events; extra pointer bit separates full from empty
module evt_fifo
  import keycode_evt_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  key_evt_t din,
  output key_evt_t dout,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);
  key_evt_t mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty   = wr_ptr == rd_ptr;
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // a pop frees the slot in the same cycle, so a full FIFO still takes a push alongside it
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/keycode_event_gen.sv
// keycode_event_gen: turns the SoC keycode into press/release/auto-repeat events queued in a FIFO
module keycode_event_gen
  import keycode_evt_pkg::*;
#(
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [7:0]          keycode_export,
  input  logic                ovf_clear,
  keycode_event_gen_if.master evt,
  output logic [7:0]          held_code,
  output logic                ovf_flag
);
  localparam int TW = $clog2(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [TW-1:0] T_DELAY  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] T_PERIOD = TW'(REPEAT_PERIOD - 1);
  state_t state, state_nxt;
  logic [7:0] kc_q, held_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic push, full, empty, drop;
  key_evt_t push_evt, head;
  assign drop = push && full && !evt.evt_ready;
  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) begin
      state     <= IDLE;
      kc_q      <= '0;
      held_code <= '0;
      timer     <= '0;
      ovf_flag  <= 1'b0;
    end else begin
      state     <= state_nxt;
      kc_q      <= keycode_export;
      held_code <= held_nxt;
      timer     <= timer_nxt;
      ovf_flag  <= drop || (ovf_flag && !ovf_clear);
    end
  always_comb begin
    state_nxt = state;
    held_nxt  = held_code;
    timer_nxt = timer;
    push      = 1'b0;
    push_evt  = '{EVT_NONE, 8'h00};
    case (state)
      IDLE: state_nxt = |kc_q ? EMIT_PRESS : IDLE;
      EMIT_REL: begin
        push      = 1'b1;
        push_evt  = '{EVT_RELEASE, held_code};
        state_nxt = |kc_q ? EMIT_PRESS : IDLE;
        held_nxt  = |kc_q ? held_code : 8'h00;
      end
      EMIT_PRESS: begin
        push      = 1'b1;
        push_evt  = '{EVT_PRESS, kc_q};
        held_nxt  = kc_q;
        timer_nxt = T_DELAY;
        state_nxt = HELD;
      end
      HELD:
        if (kc_q != held_code) state_nxt = EMIT_REL;
        else if (timer == '0) begin
          push      = |held_code;
          push_evt  = '{EVT_REPEAT, held_code};
          timer_nxt = T_PERIOD;
        end else timer_nxt = timer - 1'b1;
      default: state_nxt = IDLE;
    endcase
  end
  evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk_clk),
    .rst  (reset_reset),
    .push (push),
    .pop  (evt.evt_ready),
    .din  (push_evt),
    .dout (head),
    .full (full),
    .empty(empty)
  );
  // the stale RAM head is masked so every event output reads 0 while the queue is empty
  assign evt.evt_valid = !empty;
  assign evt.evt_type  = empty ? EVT_NONE : head.etype;
  assign evt.evt_code  = empty ? 8'h00 : head.code;
endmodule

// File: tb/tb_keycode_event_gen.sv
// tb_keycode_event_gen: directed key sequences checked every cycle against an event-queue model
module tb_keycode_event_gen;
  import keycode_evt_pkg::*;
  localparam int RD = 8, RP = 4, DEPTH = 4;
  logic clk = 1'b0, rst = 1'b1, ovf_clear = 1'b0;
  logic [7:0] kc = 8'h00;
  logic [7:0] held_code;
  logic ovf_flag;
  int vectors = 0, miscompares = 0;
  int cyc = 0;
  logic [7:0] m_kc = 8'h00, m_held = 8'h00;
  int m_pend = 0, m_age = 0;
  bit m_first = 1'b0, m_ovf = 1'b0;
  key_evt_t m_q[$];
  key_evt_t log_e[$];
  int log_cyc[$];
  key_evt_t pops[$];
  keycode_event_gen_if evt();
  keycode_event_gen #(.REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .FIFO_DEPTH(DEPTH)) dut (
    .clk_clk       (clk),
    .reset_reset   (rst),
    .keycode_export(kc),
    .ovf_clear     (ovf_clear),
    .evt           (evt),
    .held_code     (held_code),
    .ovf_flag      (ovf_flag)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  // model: pending emission (1 = release owed, 2 = press owed), age since last press/repeat push
  initial begin : model
    key_evt_t e;
    bit has, drop;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_kc = 8'h00; m_held = 8'h00; m_pend = 0; m_age = 0; m_ovf = 1'b0;
        m_q.delete();
      end else begin
        cyc++;
        has = 1'b0;
        e = '{EVT_NONE, 8'h00};
        if (m_pend == 1) begin
          e = '{EVT_RELEASE, m_held}; has = 1'b1;
          if (m_kc != 0) m_pend = 2;
          else begin m_held = 8'h00; m_pend = 0; end
        end else if (m_pend == 2) begin
          e = '{EVT_PRESS, m_kc}; has = 1'b1;
          m_held = m_kc; m_age = 1; m_first = 1'b1; m_pend = 0;
        end else if (m_kc != m_held) m_pend = (m_held != 0) ? 1 : 2;
        else if (m_held != 0) begin
          if (m_age == (m_first ? RD : RP)) begin
            e = '{EVT_REPEAT, m_held}; has = 1'b1; m_age = 1; m_first = 1'b0;
          end else m_age++;
        end
        if (evt.evt_ready && m_q.size() > 0) void'(m_q.pop_front());
        if (has) begin log_e.push_back(e); log_cyc.push_back(cyc); end
        drop = has && m_q.size() >= DEPTH;
        if (has && !drop) m_q.push_back(e);
        m_ovf = drop ? 1'b1 : (ovf_clear ? 1'b0 : m_ovf);
        m_kc = kc;
      end
    end
  end
  initial begin : compare
    key_evt_t pe;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("valid", evt.evt_valid, m_q.size() > 0);
        chk("type", evt.evt_type, m_q.size() > 0 ? m_q[0].etype : EVT_NONE);
        chk("code", evt.evt_code, m_q.size() > 0 ? m_q[0].code : 8'h00);
        chk("held", held_code, m_held);
        chk("ovf", ovf_flag, m_ovf);
        if (evt.evt_valid && evt.evt_ready) begin
          pe.etype = evt.evt_type;
          pe.code  = evt.evt_code;
          pops.push_back(pe);
        end
      end
    end
  end
  initial begin : stim
    int b, s, pb;
    evt.evt_ready = 1'b1;
    tick(1);
    chk("rst_valid", evt.evt_valid, 0);
    chk("rst_type", evt.evt_type, 0);
    chk("rst_held", held_code, 0);
    chk("rst_ovf", ovf_flag, 0);
    tick(1);
    rst = 1'b0;
    tick(2);
    b = log_e.size(); s = cyc;
    kc = 8'h04; tick(3); kc = 8'h00; tick(6);
    chk("t1_count", log_e.size() - b, 2);
    chk("t1_press", log_e[b], {EVT_PRESS, 8'h04});
    chk("t1_press_cyc", log_cyc[b] - s, 3);
    chk("t1_rel", log_e[b+1], {EVT_RELEASE, 8'h04});
    chk("t1_rel_cyc", log_cyc[b+1] - s, 6);
    chk("t1_held", held_code, 0);
    b = log_e.size(); s = cyc;
    kc = 8'h04; tick(6); kc = 8'h1A; tick(5);
    chk("t2_count", log_e.size() - b, 3);
    chk("t2_rel", log_e[b+1], {EVT_RELEASE, 8'h04});
    chk("t2_rel_cyc", log_cyc[b+1] - s, 9);
    chk("t2_press", log_e[b+2], {EVT_PRESS, 8'h1A});
    chk("t2_press_cyc", log_cyc[b+2] - s, 10);
    chk("t2_held", held_code, 8'h1A);
    kc = 8'h00; tick(5);
    b = log_e.size(); s = cyc;
    kc = 8'h2C; tick(23); kc = 8'h00; tick(5);
    chk("t3_count", log_e.size() - b, 6);
    for (int i = 0; i < 4; i++) begin
      chk("t3_rep", log_e[b+1+i], {EVT_REPEAT, 8'h2C});
      chk("t3_rep_cyc", log_cyc[b+1+i] - log_cyc[b], 8 + 4 * i);
    end
    chk("t3_rel", log_e[b+5], {EVT_RELEASE, 8'h2C});
    evt.evt_ready = 1'b0;
    b = log_e.size(); pb = pops.size(); s = cyc;
    kc = 8'h2C; tick(24);
    chk("t4_valid", evt.evt_valid, 1);
    chk("t4_ovf_set", ovf_flag, 1);
    chk("t4_drop_cyc", log_cyc[b+4] - s, 23);
    ovf_clear = 1'b1; tick(1); ovf_clear = 1'b0;
    chk("t4_ovf_clr", ovf_flag, 0);
    tick(1);
    evt.evt_ready = 1'b1; tick(1); evt.evt_ready = 1'b0;
    chk("t5_ovf", ovf_flag, 0);
    chk("t5_valid", evt.evt_valid, 1);
    kc = 8'h00; evt.evt_ready = 1'b1; tick(8);
    chk("t4_pops", pops.size() - pb, 6);
    for (int i = 0; i < 6; i++)
      chk("t4_drain", pops[pb+i], {(i == 0) ? EVT_PRESS : (i == 5) ? EVT_RELEASE : EVT_REPEAT, 8'h2C});
    evt.evt_ready = 1'b0;
    kc = 8'h04; tick(12);
    chk("t6_pre_valid", evt.evt_valid, 1);
    rst = 1'b1; #1;
    chk("t6_valid", evt.evt_valid, 0);
    chk("t6_type", evt.evt_type, 0);
    chk("t6_code", evt.evt_code, 0);
    chk("t6_held", held_code, 0);
    chk("t6_ovf", ovf_flag, 0);
    tick(1);
    rst = 1'b0;
    b = log_e.size(); s = cyc;
    tick(5);
    chk("t6_count", log_e.size() - b, 1);
    chk("t6_press", log_e[b], {EVT_PRESS, 8'h04});
    chk("t6_press_cyc", log_cyc[b] - s, 3);
    kc = 8'h00; evt.evt_ready = 1'b1; tick(6);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
